// File: rtl/axis_frame_generator.sv
`default_nettype none
// ============================================================================
//  Module      : axis_frame_generator
//  Description : AXI4-Stream test-pattern source. Emits framed bursts of a
//                32-bit ramp (start_value, +step per accepted beat) with
//                tlast on the final beat of each frame. A run is a fixed
//                number of frames, or runs without end when num_frames is 0.
//                Optional build macro AXIS_GEN_LFSR_EN adds a pattern_sel
//                input that selects a 32-bit Fibonacci LFSR instead of the
//                ramp.
//  Ports       : aclk, aresetn        - clock, async active-low reset
//                m_axis_*             - AXI4-Stream master (tstrb fixed 4'hF)
//                en                   - run request
//                frame_len            - words per frame (0 behaves as 1)
//                num_frames           - frames per run (0 = continuous)
//                start_value, step    - ramp start / increment (LFSR seed)
//                pattern_sel          - LFSR select (AXIS_GEN_LFSR_EN only)
//                busy, done           - run in progress / run complete
//                word_count           - accepted beats since reset
//                frame_count          - completed frames since reset
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_generator (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        m_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   output logic [3:0]  m_axis_tstrb,
   input  logic        en,
   input  logic [15:0] frame_len,
   input  logic [15:0] num_frames,
   input  logic [31:0] start_value,
   input  logic [7:0]  step,
`ifdef AXIS_GEN_LFSR_EN
   input  logic        pattern_sel,
`endif
   output logic        busy,
   output logic        done,
   output logic [31:0] word_count,
   output logic [31:0] frame_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  r_state;
   logic [31:0] r_data;
   logic [15:0] r_len_m1;       // latched frame length minus one
   logic [15:0] r_num_frames;
   logic [15:0] r_beat_idx;
   logic [15:0] r_frame_idx;
   logic [7:0]  r_step;
   logic        r_stop;         // en was seen low during this run
   logic [31:0] r_word_count;
   logic [31:0] r_frame_count;

   logic        w_accept;
   logic        w_last;
   logic        w_run_done;
   logic [15:0] w_frame_idx_next;
   logic [15:0] w_len_m1;
   logic [31:0] w_seed;
   logic [31:0] w_data_next;

`ifdef AXIS_GEN_LFSR_EN
   logic        r_pat;

   // Fibonacci LFSR, taps 32,22,2,1 (bits 31,21,1,0), shifting toward MSB
   function automatic logic [31:0] f_lfsr(input logic [31:0] d);
      return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
   endfunction

   // An all-zero seed would lock the LFSR, so it is replaced with 1
   assign w_seed      = (pattern_sel && (start_value == 32'd0)) ? 32'd1 : start_value;
   assign w_data_next = r_pat ? f_lfsr(r_data) : (r_data + {24'd0, r_step});
`else
   assign w_seed      = start_value;
   assign w_data_next = r_data + {24'd0, r_step};
`endif

   assign w_len_m1         = (frame_len == 16'd0) ? 16'd0 : (frame_len - 16'd1);
   assign w_accept         = (r_state == S_SEND) && m_axis_tready;
   assign w_last           = (r_beat_idx == r_len_m1);
   assign w_frame_idx_next = r_frame_idx + 16'd1;
   assign w_run_done       = (r_num_frames != 16'd0) && (w_frame_idx_next == r_num_frames);

   // Outputs decode directly from state so reset clears them asynchronously
   assign m_axis_tvalid = (r_state == S_SEND);
   assign m_axis_tlast  = (r_state == S_SEND) && w_last;
   assign m_axis_tdata  = r_data;
   assign m_axis_tstrb  = 4'hF;
   assign busy          = (r_state == S_SEND);
   assign done          = (r_state == S_DONE);
   assign word_count    = r_word_count;
   assign frame_count   = r_frame_count;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state       <= S_IDLE;
         r_data        <= 32'd0;
         r_len_m1      <= 16'd0;
         r_num_frames  <= 16'd0;
         r_beat_idx    <= 16'd0;
         r_frame_idx   <= 16'd0;
         r_step        <= 8'd0;
         r_stop        <= 1'b0;
         r_word_count  <= 32'd0;
         r_frame_count <= 32'd0;
`ifdef AXIS_GEN_LFSR_EN
         r_pat         <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (en) begin
                  r_len_m1     <= w_len_m1;
                  r_num_frames <= num_frames;
                  r_step       <= step;
                  r_data       <= w_seed;
                  r_beat_idx   <= 16'd0;
                  r_frame_idx  <= 16'd0;
                  r_stop       <= 1'b0;
`ifdef AXIS_GEN_LFSR_EN
                  r_pat        <= pattern_sel;
`endif
                  r_state      <= S_SEND;
               end
            end
            S_SEND: begin
               if (!en) begin
                  r_stop <= 1'b1;
               end
               if (w_accept) begin
                  r_data       <= w_data_next;
                  r_word_count <= r_word_count + 32'd1;
                  if (w_last) begin
                     r_frame_count <= r_frame_count + 32'd1;
                     r_beat_idx    <= 16'd0;
                     r_frame_idx   <= w_frame_idx_next;
                     // A completed run takes precedence over a stop request
                     if (w_run_done) begin
                        r_state <= S_DONE;
                     end else if (r_stop || !en) begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_beat_idx <= r_beat_idx + 16'd1;
                  end
               end
            end
            S_DONE: begin
               if (!en) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_frame_generator
//  Description : Self-checking bench for axis_frame_generator. Runs directed
//                and randomized runs against a behavioural model of the
//                expected beat stream (ramp or LFSR sequence, frame
//                boundaries, run termination and counters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_generator;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        m_axis_tready = 1'b0;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic [3:0]  m_axis_tstrb;
   logic        en = 1'b0;
   logic [15:0] frame_len = 16'd0;
   logic [15:0] num_frames = 16'd0;
   logic [31:0] start_value = 32'd0;
   logic [7:0]  step = 8'd0;
`ifdef AXIS_GEN_LFSR_EN
   logic        pattern_sel = 1'b0;
`endif
   logic        busy;
   logic        done;
   logic [31:0] word_count;
   logic [31:0] frame_count;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] m_words = 32'd0;
   logic [31:0] m_frames = 32'd0;

   axis_frame_generator dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tstrb  (m_axis_tstrb),
      .en            (en),
      .frame_len     (frame_len),
      .num_frames    (num_frames),
      .start_value   (start_value),
      .step          (step),
`ifdef AXIS_GEN_LFSR_EN
      .pattern_sel   (pattern_sel),
`endif
      .busy          (busy),
      .done          (done),
      .word_count    (word_count),
      .frame_count   (frame_count)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference LFSR: x^32 + x^22 + x^2 + x + 1, new bit enters at the LSB
   function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
      logic fb;
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      return {s[30:0], fb};
   endfunction

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
      chk({tag, "_busy"},   32'(busy),          32'd0);
      chk({tag, "_words"},  word_count,         m_words);
      chk({tag, "_frames"}, frame_count,        m_frames);
   endtask

   // One run from S_IDLE. Called at a falling edge with en low.
   // drop_after: drop en once this many beats are accepted (-1 = never).
   // rmode: 0 tready high, 1 tready pattern 1,0,0,1, 2 random tready.
   task automatic run_frames(input logic [15:0] len, input logic [15:0] nf,
                             input logic [31:0] sv, input logic [7:0] st,
                             input logic pat, input int drop_after, input int rmode);
      int          L;
      int          k;
      int          frames;
      int          cyc;
      logic [31:0] exp_d;
      logic        exp_last;
      bit          finished;
      bit          to_done;

      L        = (len == 16'd0) ? 1 : int'(len);
      k        = 0;
      frames   = 0;
      cyc      = 0;
      finished = 0;
      to_done  = 0;
      exp_d    = (pat && sv == 32'd0) ? 32'd1 : sv;

      frame_len   = len;
      num_frames  = nf;
      start_value = sv;
      step        = st;
`ifdef AXIS_GEN_LFSR_EN
      pattern_sel = pat;
`endif
      m_axis_tready = 1'b0;
      en = 1'b1;
      @(negedge aclk);
      chk("first_valid", 32'(m_axis_tvalid), 32'd1);

      // Configuration changes mid-run must not disturb the stream
      frame_len   = 16'($urandom);
      num_frames  = 16'($urandom);
      start_value = $urandom;
      step        = 8'($urandom);
`ifdef AXIS_GEN_LFSR_EN
      pattern_sel = 1'($urandom);
`endif

      while (!finished) begin
         exp_last = ((k % L) == (L - 1));
         chk("tvalid", 32'(m_axis_tvalid), 32'd1);
         chk("tdata",  m_axis_tdata,        exp_d);
         chk("tlast",  32'(m_axis_tlast),   32'(exp_last));
         case (rmode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
         cyc++;
         if (m_axis_tready) begin
            k++;
            m_words = m_words + 32'd1;
            exp_d = pat ? ref_lfsr(exp_d) : (exp_d + {24'd0, st});
            if (k == drop_after) en = 1'b0;
            if (exp_last) begin
               m_frames = m_frames + 32'd1;
               frames++;
               if (nf != 16'd0 && frames == int'(nf)) begin
                  finished = 1;
                  to_done  = 1;
               end else if (!en) begin
                  finished = 1;
               end
            end
         end
         @(negedge aclk);
         if (cyc > 3000 && !finished) begin
            chk("timeout", 32'd0, 32'd1);
            finished = 1;
            en = 1'b0;
            repeat (Lmax(L)) @(negedge aclk);
         end
      end

      m_axis_tready = 1'($urandom_range(0, 1));
      chk("end_done", 32'(done), 32'(to_done));
      check_idle_outputs("end");
      if (to_done) begin
         // en still high: the run must not restart
         repeat (2) @(negedge aclk);
         chk("hold_done",   32'(done),          32'd1);
         chk("hold_tvalid", 32'(m_axis_tvalid), 32'd0);
         en = 1'b0;
         @(negedge aclk);
         chk("done_exit", 32'(done), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
      end
      m_axis_tready = 1'b0;
   endtask

   function automatic int Lmax(input int l);
      return l + 4;
   endfunction

   task automatic reset_mid_frame();
      frame_len   = 16'd8;
      num_frames  = 16'd0;
      start_value = $urandom;
      step        = 8'd5;
      m_axis_tready = 1'b1;
      en = 1'b1;
      repeat (4) @(negedge aclk);
      #2 aresetn = 1'b0;
      #1;
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
      chk("rst_tdata",  m_axis_tdata,        32'd0);
      chk("rst_words",  word_count,          32'd0);
      chk("rst_frames", frame_count,         32'd0);
      chk("rst_busy",   32'(busy),           32'd0);
      en = 1'b0;
      m_words  = 32'd0;
      m_frames = 32'd0;
      @(negedge aclk);
      aresetn = 1'b1;
      repeat (3) begin
         @(negedge aclk);
         chk("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      end
      check_idle_outputs("post_rst");
      m_axis_tready = 1'b0;
   endtask

   initial begin
      #1;
      chk("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("reset_done",   32'(done),          32'd0);
      chk("reset_busy",   32'(busy),          32'd0);
      chk("reset_words",  word_count,         32'd0);
      chk("reset_frames", frame_count,        32'd0);
      chk("tstrb",        32'(m_axis_tstrb),  32'hF);
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);

      // Basic ramp: 10,13,..,31 in two 4-beat frames
      run_frames(16'd4, 16'd2, 32'd10, 8'd3, 1'b0, -1, 0);
      chk("ramp_words",  word_count,  32'd8);
      chk("ramp_frames", frame_count, 32'd2);

      // Backpressure, single 3-beat frame
      run_frames(16'd3, 16'd1, 32'd100, 8'd1, 1'b0, -1, 1);
      // Early stop in a continuous run
      run_frames(16'd5, 16'd0, 32'hFFFF_FFF0, 8'd7, 1'b0, 2, 0);
      // Zero length frames
      run_frames(16'd0, 16'd3, 32'd77, 8'd2, 1'b0, -1, 2);

      for (int i = 0; i < 12; i++) begin
         logic [15:0] rl;
         logic [15:0] rn;
         rl = 16'($urandom_range(0, 6));
         rn = 16'($urandom_range(0, 3));
         run_frames(rl, rn, $urandom, 8'($urandom), 1'b0,
                    (rn == 16'd0) ? int'($urandom_range(1, 12)) : -1,
                    int'($urandom_range(0, 2)));
      end

      reset_mid_frame();

`ifdef AXIS_GEN_LFSR_EN
      run_frames(16'd16, 16'd1, 32'd0, 8'hAB, 1'b1, -1, 0);
      run_frames(16'd5, 16'd2, $urandom, 8'h11, 1'b1, -1, 2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
